bsram_boot_arb: RTL and testbench
=================================

BSRAM_BOOT_ARB -- requirements
Module: bsram_boot_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, BSRAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, BSRAM word width.
REQ-003 The block SHALL have parameter BOOT_LEN, default 17, program words loaded per boot (1..2**ADDR_W).
REQ-004 The block SHALL have these ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- src_valid  in  1  boot word valid.
- src_data  in  DATA_W  boot word.
- src_ready  out  1  boot word accepted when high with src_valid.
- boot_start  in  1  one-cycle pulse; restarts boot from RUN or ERROR.
- cpu_addr  in  ADDR_W  CPU fetch word address (pc/2).
- cpu_rst_n  out  1  CPU reset, active-low.
- cpu_stall  out  1  dout invalid for CPU this cycle.
- dbg_req  in  1  debug write request, held until ack.
- dbg_addr  in  ADDR_W  debug write address.
- dbg_data  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle grant pulse.
- mem_ce  out  1  BSRAM chip enable.
- mem_wre  out  1  BSRAM write enable.
- mem_ad  out  ADDR_W  BSRAM address.
- mem_din  out  DATA_W  BSRAM write data.
- boot_done  out  1  high in RUN.
- boot_err  out  1  high in ERROR.

Function
REQ-005 The FSM SHALL have states LOAD, DRAIN, RUN and ERROR; it leaves reset in LOAD.
REQ-006 In LOAD, src_ready SHALL be 1; each handshake registers mem_wre=1, mem_ad=wr_addr and mem_din=src_data for the next cycle, then increments wr_addr.
REQ-007 Back-to-back handshakes SHALL produce back-to-back single-cycle writes; mem_wre SHALL be 0 in any cycle after a non-handshake cycle.
REQ-008 The word counter SHALL be ADDR_W+1 bits wide; wr_addr SHALL wrap modulo 2**ADDR_W.
REQ-009 After the BOOT_LEN-th data handshake, src_ready SHALL drop the next cycle and the FSM SHALL enter DRAIN for 1 cycle (the final write), then enter RUN.
REQ-010 cpu_rst_n SHALL be 0 outside RUN and SHALL rise 1 cycle after RUN is entered; boot_done SHALL equal (state==RUN).
REQ-011 In RUN with no debug grant, mem_ad SHALL equal cpu_addr combinationally, with mem_wre=0 and mem_ce=1.
REQ-012 In RUN, dbg_req=1 SHALL be granted the next cycle: mem_wre=1, mem_ad=dbg_addr, mem_din=dbg_data, dbg_ack=1 for exactly 1 cycle.
REQ-013 cpu_stall SHALL be 1 in the grant cycle and the following cycle; otherwise it SHALL be 0.
REQ-014 dbg_req SHALL be ignored in the cycle after dbg_ack, and always outside RUN (no ack).
REQ-015 In RUN or ERROR, boot_start SHALL cause the next state to be LOAD with wr_addr and counter cleared; cpu_rst_n SHALL fall that same next cycle.
REQ-016 boot_start SHALL win over a simultaneous dbg_req (no ack); in LOAD or DRAIN, boot_start SHALL be ignored.
REQ-017 src_ready SHALL be 0 outside LOAD; src_data SHALL never be written outside LOAD handshakes.

Reset
REQ-018 On rst_n low, the block SHALL asynchronously set state=LOAD, wr_addr=0, counter=0, mem_wre=0, mem_ad=0, mem_din=0, mem_ce=1, cpu_rst_n=0, dbg_ack=0, cpu_stall=1, src_ready=0, boot_done=0, boot_err=0.
REQ-019 src_ready SHALL first rise 1 cycle after rst_n deasserts; reset mid-LOAD SHALL discard progress.

Configuration
REQ-020 With BOOT_CHECKSUM_EN defined, LOAD SHALL accept BOOT_LEN+1 words; the last word is a checksum and SHALL not be written.
REQ-021 With BOOT_CHECKSUM_EN, the checksum SHALL be compared against the sum modulo 2**DATA_W of the data words: a match proceeds to DRAIN, a mismatch enters ERROR (boot_err=1, cpu_rst_n=0).
REQ-022 Without BOOT_CHECKSUM_EN, BOOT_LEN words SHALL be accepted, boot_err SHALL be tied 0, and ERROR SHALL be unreachable.

Verification
REQ-023 Stream 17 words with src_valid always high -> 17 consecutive mem_wre pulses at addresses 0..16, then DRAIN, RUN, and cpu_rst_n=1 at cycle 19 after the first handshake.
REQ-024 Insert src_valid gaps every other cycle -> writes only on handshake cycles, with correct data at addresses 0..16.
REQ-025 In RUN, cpu_addr=5 and dbg_req with addr 3 / data 16'h00A1 -> next cycle mem_ad=3, wre=1, dbg_ack=1, cpu_stall high for 2 cycles, then mem_ad=5.
REQ-026 boot_start and dbg_req in the same RUN cycle -> LOAD, no dbg_ack, cpu_rst_n=0.
REQ-027 With BOOT_CHECKSUM_EN, send 17 words plus a wrong checksum -> boot_err=1 and cpu_rst_n stays 0; a boot_start then a correct stream -> RUN.
REQ-028 Assert rst_n low mid-LOAD at word 8 -> outputs take REQ-018 values immediately; a reload restarts at address 0.

Source files
------------

// File: rtl/bsram_boot_arb_if.sv
// bsram_boot_arb_if: boot stream, CPU fetch, debug write and BSRAM port signals of the boot arbiter.
interface bsram_boot_arb_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              boot_start;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rst_n;
    logic              cpu_stall;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ack;
    logic              mem_ce;
    logic              mem_wre;
    logic [ADDR_W-1:0] mem_ad;
    logic [DATA_W-1:0] mem_din;
    logic              boot_done;
    logic              boot_err;
    modport slave (
        input  src_valid, src_data, boot_start, cpu_addr, dbg_req, dbg_addr, dbg_data,
        output src_ready, cpu_rst_n, cpu_stall, dbg_ack, mem_ce, mem_wre, mem_ad, mem_din,
               boot_done, boot_err
    );
    modport master (
        output src_valid, src_data, boot_start, cpu_addr, dbg_req, dbg_addr, dbg_data,
        input  src_ready, cpu_rst_n, cpu_stall, dbg_ack, mem_ce, mem_wre, mem_ad, mem_din,
               boot_done, boot_err
    );
endinterface

// File: rtl/bsram_boot_arb.sv
// bsram_boot_arb: loads a boot image into BSRAM, then shares the port between CPU fetch and debug writes.
// Define BOOT_CHECKSUM_EN to require a trailing checksum word (modular sum of the image).
module bsram_boot_arb #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int BOOT_LEN = 17
) (
    input logic clk,
    input logic rst_n,
    bsram_boot_arb_if.slave bus
);
    typedef enum logic [1:0] {LOAD, DRAIN, RUN, ERROR} state_t;
    localparam int CW = ADDR_W + 1;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [CW-1:0] LAST = CW'(BOOT_LEN);
`else
    localparam logic [CW-1:0] LAST = CW'(BOOT_LEN - 1);
`endif
    state_t            state;
    logic [ADDR_W-1:0] wr_addr, ad_q;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] din_q;
    logic              wre_q, ack_q, stall_q, ready_q, cpu_rst_q;
    logic              hs, last, restart, grant, is_ck, ck_ok;
    assign hs      = state == LOAD && ready_q && bus.src_valid;
    assign last    = cnt == LAST;
    assign restart = (state == RUN || state == ERROR) && bus.boot_start;
    // a request seen during its own ack cycle is the same request, not a new one
    assign grant   = state == RUN && bus.dbg_req && !bus.boot_start && !ack_q;
`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    assign is_ck = last;
    assign ck_ok = sum == bus.src_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum <= '0;
        else if (restart) sum <= '0;
        else if (hs && !is_ck) sum <= sum + bus.src_data;
    end
`else
    assign is_ck = 1'b0;
    assign ck_ok = 1'b1;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            wr_addr   <= '0;
            cnt       <= '0;
            wre_q     <= 1'b0;
            ad_q      <= '0;
            din_q     <= '0;
            cpu_rst_q <= 1'b0;
            ack_q     <= 1'b0;
            stall_q   <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            wre_q     <= (hs && !is_ck) || grant;
            ack_q     <= grant;
            stall_q   <= grant || ack_q;
            cpu_rst_q <= state == RUN && !bus.boot_start;
            ready_q   <= state == LOAD && !(hs && last);
            if (hs && !is_ck) begin
                ad_q    <= wr_addr;
                din_q   <= bus.src_data;
                wr_addr <= wr_addr + ADDR_W'(1);
            end else if (grant) begin
                ad_q  <= bus.dbg_addr;
                din_q <= bus.dbg_data;
            end
            if (hs) cnt <= cnt + CW'(1);
            if (restart) begin
                wr_addr <= '0;
                cnt     <= '0;
            end
            state <= restart ? LOAD :
                     (hs && last) ? (ck_ok ? DRAIN : ERROR) :
                     state == DRAIN ? RUN : state;
        end
    end
    assign bus.src_ready = ready_q;
    assign bus.mem_ce    = 1'b1;
    assign bus.mem_wre   = wre_q;
    assign bus.mem_ad    = (state == RUN && !ack_q) ? bus.cpu_addr : ad_q;
    assign bus.mem_din   = din_q;
    assign bus.cpu_rst_n = cpu_rst_q;
    assign bus.cpu_stall = stall_q;
    assign bus.dbg_ack   = ack_q;
    assign bus.boot_done = state == RUN;
`ifdef BOOT_CHECKSUM_EN
    assign bus.boot_err  = state == ERROR;
`else
    assign bus.boot_err  = 1'b0;
`endif
endmodule

// File: tb/tb_bsram_boot_arb.sv
// tb_bsram_boot_arb: random boot images and debug writes checked against an expected image and write log.
module tb_bsram_boot_arb;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int BL = 17;
`ifdef BOOT_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NW = BL + CK;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bsram_boot_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    bsram_boot_arb #(.ADDR_W(AW), .DATA_W(DW), .BOOT_LEN(BL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;
    int wn = 0;
    int base = 0;
    logic [AW-1:0] wa [0:4095];
    logic [DW-1:0] wd [0:4095];
    logic [DW-1:0] words [0:BL];

    // BSRAM-side write log: every write the DUT actually issues
    always @(posedge clk) begin
        if (bus.mem_wre === 1'b1 && wn < 4096) begin
            wa[wn] <= bus.mem_ad;
            wd[wn] <= bus.mem_din;
            wn <= wn + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_values();
        check("rst_ready", bus.src_ready, 0);
        check("rst_wre", bus.mem_wre, 0);
        check("rst_ad", bus.mem_ad, 0);
        check("rst_din", bus.mem_din, 0);
        check("rst_ce", bus.mem_ce, 1);
        check("rst_cpu_rst", bus.cpu_rst_n, 0);
        check("rst_ack", bus.dbg_ack, 0);
        check("rst_stall", bus.cpu_stall, 1);
        check("rst_done", bus.boot_done, 0);
        check("rst_err", bus.boot_err, 0);
    endtask

    // sends n words of a fresh random image (checksum word last); bad_ck corrupts the checksum
    task automatic load(input bit gaps, input bit bad_ck, input int n);
        int i = 0;
        int cyc = 0;
        bit prev_data = 0;
        logic [DW-1:0] s = '0;
        for (int k = 0; k < BL; k++) begin
            words[k] = DW'($urandom);
            s = s + words[k];
        end
        words[BL] = bad_ck ? s + 1'b1 : s;
        base = wn;
        while (i < n && cyc < 200) begin
            @(negedge clk);
            check("load_wre", bus.mem_wre, prev_data);
            bus.src_valid = !gaps || (cyc % 2) == 0;
            bus.src_data = words[i];
            bus.boot_start = cyc == 3;
            #1;
            prev_data = bus.src_valid && bus.src_ready && i < BL;
            if (bus.src_valid && bus.src_ready) i++;
            cyc++;
        end
        bus.boot_start = 1'b0;
        check("load_words", i, n);
        check("load_cycles", cyc, gaps ? 2 * n - 1 : n);
    endtask

    task automatic finish_load(input bit ok);
        @(negedge clk);
        bus.src_valid = 1'b0;
        #1;
        check("drain_ready", bus.src_ready, 0);
        check("drain_cpu_rst", bus.cpu_rst_n, 0);
        check("drain_done", bus.boot_done, 0);
        check("drain_err", bus.boot_err, !ok);
        check("drain_wre", bus.mem_wre, CK == 0);
        @(negedge clk);
        #1;
        check("log_count", wn - base, BL);
        for (int k = 0; k < BL; k++) begin
            check("log_addr", wa[base + k], k);
            check("log_data", wd[base + k], words[k]);
        end
        check("run_done", bus.boot_done, ok);
        check("run_err", bus.boot_err, !ok);
        check("run_cpu_rst_low", bus.cpu_rst_n, 0);
        check("run_wre", bus.mem_wre, 0);
        @(negedge clk);
        bus.cpu_addr = AW'($urandom);
        #1;
        check("cpu_rst_rise", bus.cpu_rst_n, ok);
        check("run_stall", bus.cpu_stall, 0);
        check("run_ready", bus.src_ready, 0);
        if (ok) begin
            check("run_ad", bus.mem_ad, bus.cpu_addr);
            check("run_ce", bus.mem_ce, 1);
        end
    endtask

    task automatic dbg_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [AW-1:0] ca);
        @(negedge clk);
        bus.cpu_addr = ca;
        bus.dbg_req = 1'b1;
        bus.dbg_addr = a;
        bus.dbg_data = d;
        #1;
        check("dbg_pre_ad", bus.mem_ad, ca);
        check("dbg_pre_ack", bus.dbg_ack, 0);
        check("dbg_pre_stall", bus.cpu_stall, 0);
        @(negedge clk);
        #1;
        check("dbg_ad", bus.mem_ad, a);
        check("dbg_din", bus.mem_din, d);
        check("dbg_wre", bus.mem_wre, 1);
        check("dbg_ack", bus.dbg_ack, 1);
        check("dbg_stall", bus.cpu_stall, 1);
        @(negedge clk);
        #1;
        check("dbg_post_ack", bus.dbg_ack, 0);
        check("dbg_post_wre", bus.mem_wre, 0);
        check("dbg_post_stall", bus.cpu_stall, 1);
        check("dbg_post_ad", bus.mem_ad, ca);
        bus.dbg_req = 1'b0;
        @(negedge clk);
        #1;
        check("dbg_end_stall", bus.cpu_stall, 0);
        check("dbg_end_ack", bus.dbg_ack, 0);
        check("dbg_log_addr", wa[wn - 1], a);
        check("dbg_log_data", wd[wn - 1], d);
    endtask

    task automatic restart(input bit with_dbg);
        @(negedge clk);
        bus.boot_start = 1'b1;
        bus.dbg_req = with_dbg;
        bus.dbg_addr = AW'($urandom);
        bus.dbg_data = DW'($urandom);
        @(negedge clk);
        bus.boot_start = 1'b0;
        #1;
        check("restart_ack", bus.dbg_ack, 0);
        check("restart_cpu_rst", bus.cpu_rst_n, 0);
        check("restart_done", bus.boot_done, 0);
        check("restart_err", bus.boot_err, 0);
        check("restart_ready", bus.src_ready, 0);
        @(negedge clk);
        #1;
        check("load_no_ack", bus.dbg_ack, 0);
        check("load_no_wre", bus.mem_wre, 0);
        check("load_ready", bus.src_ready, 1);
        bus.dbg_req = 1'b0;
    endtask

    initial begin
        bus.src_valid = 1'b0;
        bus.src_data = '0;
        bus.boot_start = 1'b0;
        bus.cpu_addr = '0;
        bus.dbg_req = 1'b0;
        bus.dbg_addr = '0;
        bus.dbg_data = '0;
        #3 rst_n = 1'b0;
        #1 reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_ready_low", bus.src_ready, 0);
        @(negedge clk);
        #1 check("rel_ready_high", bus.src_ready, 1);
        load(1'b0, 1'b0, NW);
        finish_load(1'b1);
        dbg_write(AW'(3), DW'(16'h00A1), AW'(5));
        for (int r = 0; r < 3; r++) dbg_write(AW'($urandom), DW'($urandom), AW'($urandom));
        restart(1'b1);
        load(1'b1, 1'b0, NW);
        finish_load(1'b1);
`ifdef BOOT_CHECKSUM_EN
        restart(1'b0);
        load(1'b0, 1'b1, NW);
        finish_load(1'b0);
        restart(1'b0);
        load(1'b0, 1'b0, NW);
        finish_load(1'b1);
`endif
        restart(1'b0);
        load(1'b0, 1'b0, 8);
        @(negedge clk);
        rst_n = 1'b0;
        bus.src_valid = 1'b0;
        #1 reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel2_ready_low", bus.src_ready, 0);
        @(negedge clk);
        #1 check("rel2_ready_high", bus.src_ready, 1);
        load(1'b0, 1'b0, NW);
        finish_load(1'b1);
        dbg_write(AW'($urandom), DW'($urandom), AW'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
